// File: rtl/traffic_phase_ctrl_if.sv
// Key/night/pedestrian inputs and lamp/countdown outputs of the intersection controller.
// The bench or key-debounce side is the master; the controller is the slave.
interface traffic_phase_ctrl_if #(
    parameter int NUM_DIR = 2
);
    logic               key_value;
    logic               key_valid;
    logic               night_mode;
    logic [NUM_DIR-1:0] ped_req;
    logic [NUM_DIR-1:0] red;
    logic [NUM_DIR-1:0] yellow;
    logic [NUM_DIR-1:0] green;
    logic [1:0]         active_dir;
    logic [7:0]         sec_left;

    modport master (
        output key_value, key_valid, night_mode, ped_req,
        input  red, yellow, green, active_dir, sec_left
    );

    modport slave (
        input  key_value, key_valid, night_mode, ped_req,
        output red, yellow, green, active_dir, sec_left
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// N-direction intersection controller: round-robin green, pedestrian cut, night flash,
// key-toggled all-red hold, registered lamps and a seconds countdown for the overlay.
module traffic_phase_ctrl #(
    parameter int CLK_FREQ     = 125_000_000,
    parameter int NUM_DIR      = 2,
    parameter int GREEN_TIME   = 10,
    parameter int MIN_GREEN    = 4,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 2
) (
    input  logic                 clk_125M,
    input  logic                 rstn,
    traffic_phase_ctrl_if.slave  bus
);
    localparam int              PW         = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_FREQ - 1);
    localparam logic [PW-1:0]   PRESC_HALF = PW'(CLK_FREQ / 2);
    localparam logic [7:0]      T_GREEN    = 8'(GREEN_TIME);
    localparam logic [7:0]      T_YELLOW   = 8'(YELLOW_TIME);
    localparam logic [7:0]      T_ALL_RED  = 8'(ALL_RED_TIME);
    // A tick at this sec_left or below completes MIN_GREEN full seconds of green.
    localparam logic [7:0]      CUT_LIMIT  = 8'(GREEN_TIME - MIN_GREEN + 1);
    localparam logic [1:0]      DIR_LAST   = 2'(NUM_DIR - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GREEN,
        S_YELLOW,
        S_ALL_RED,
        S_FLASH,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [7:0]         sec_q, sec_d;
    logic [1:0]         dir_q, dir_d;
    logic [1:0]         next_dir_q, next_dir_d;
    logic               hold_q, hold_d;
    logic               key_q, key_d;
    logic               key_prev_q;
    logic [NUM_DIR-1:0] ped_q, ped_d;
    logic [NUM_DIR-1:0] red_q, red_d;
    logic [NUM_DIR-1:0] yellow_q, yellow_d;
    logic [NUM_DIR-1:0] green_q, green_d;
    logic [NUM_DIR-1:0] own_dir;
    logic [NUM_DIR-1:0] own_next;

    logic tick;
    logic expire;
    logic key_edge;
    logic hold_rise;
    logic entering;
    logic cut_req;

    for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_dir
        assign own_dir[gi]  = (dir_q == 2'(gi));
        assign own_next[gi] = (next_dir_q == 2'(gi));
    end

    assign tick      = (presc_q == PRESC_LAST);
    assign expire    = tick && (sec_q == 8'd1);
    assign key_d     = bus.key_valid ? bus.key_value : key_q;
    // Edge is taken on the stored level, so hold flips the cycle after the store.
    assign key_edge  = key_q & ~key_prev_q;
    assign hold_d    = hold_q ^ key_edge;
    assign hold_rise = hold_d & ~hold_q;
    assign cut_req   = |(ped_q & ~own_dir);
    assign entering  = (state_d != state_q);

    always_comb begin
        state_d = state_q;
        if (hold_rise) begin
            state_d = S_HOLD;
        end else begin
            case (state_q)
                S_IDLE:    state_d = S_ALL_RED;
                S_GREEN:   if (expire || (tick && cut_req && (sec_q <= CUT_LIMIT)))
                               state_d = S_YELLOW;
                S_YELLOW:  if (expire) state_d = S_ALL_RED;
                S_ALL_RED: if (expire) state_d = bus.night_mode ? S_FLASH : S_GREEN;
                S_FLASH:   if (!bus.night_mode) state_d = S_ALL_RED;
                S_HOLD:    if (!hold_d) state_d = S_ALL_RED;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        presc_d    = (entering || tick) ? '0 : presc_q + 1'b1;
        sec_d      = sec_q;
        dir_d      = dir_q;
        next_dir_d = next_dir_q;
        if (entering) begin
            case (state_d)
                S_GREEN:   sec_d = T_GREEN;
                S_YELLOW:  sec_d = T_YELLOW;
                S_ALL_RED: sec_d = T_ALL_RED;
                default:   sec_d = 8'd0;
            endcase
            if (state_d == S_GREEN) begin
                dir_d      = next_dir_q;
                next_dir_d = (next_dir_q == DIR_LAST) ? 2'd0 : next_dir_q + 2'd1;
            end
            if (state_d == S_FLASH) begin
                next_dir_d = 2'd0;
            end
        end else if (tick && (sec_q != 8'd0)) begin
            sec_d = sec_q - 8'd1;
        end
    end

    // The owner's own request is dropped while it holds green; its latch clears on entry.
    always_comb begin
        ped_d = ped_q | (bus.ped_req & ((state_q == S_GREEN) ? ~own_dir : '1));
        if (entering && (state_d == S_GREEN)) begin
            ped_d = ped_d & ~own_next;
        end
    end

    always_comb begin
        red_d    = '1;
        yellow_d = '0;
        green_d  = '0;
        case (state_q)
            S_GREEN: begin
                green_d = own_dir;
                red_d   = ~own_dir;
            end
            S_YELLOW: begin
                yellow_d = own_dir;
                red_d    = ~own_dir;
            end
            S_FLASH: begin
                red_d    = '0;
                yellow_d = (presc_q < PRESC_HALF) ? '1 : '0;
            end
            default: begin
                red_d = '1;
            end
        endcase
    end

    always_ff @(posedge clk_125M or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            sec_q      <= 8'd0;
            dir_q      <= 2'd0;
            next_dir_q <= 2'd0;
            hold_q     <= 1'b0;
            key_q      <= 1'b0;
            key_prev_q <= 1'b0;
            ped_q      <= '0;
            red_q      <= '1;
            yellow_q   <= '0;
            green_q    <= '0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            dir_q      <= dir_d;
            next_dir_q <= next_dir_d;
            hold_q     <= hold_d;
            key_q      <= key_d;
            key_prev_q <= key_q;
            ped_q      <= ped_d;
            red_q      <= red_d;
            yellow_q   <= yellow_d;
            green_q    <= green_d;
        end
    end

    assign bus.red        = red_q;
    assign bus.yellow     = yellow_q;
    assign bus.green      = green_q;
    assign bus.active_dir = dir_q;
    assign bus.sec_left   = sec_q;

endmodule
